// File: rtl/stopwatch_ctrl_if.sv
// Board/chain-side signal bundle for stopwatch_ctrl: divider tick, raw buttons, chain status
// and the controls issued to the mm:ss count cells.
interface stopwatch_ctrl_if;
  logic       tick;
  logic       btn_ss;
  logic       btn_lap;
  logic       btn_clr;
  logic       chain_at_max;
  logic       inc;
  logic       clr;
  logic       lap_hold;
  logic       running;
  logic [1:0] state;

  modport master (
    output tick, btn_ss, btn_lap, btn_clr, chain_at_max,
    input  inc, clr, lap_hold, running, state
  );

  modport slave (
    input  tick, btn_ss, btn_lap, btn_clr, chain_at_max,
    output inc, clr, lap_hold, running, state
  );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Run-control sequencer for the stopwatch digit chain: button sync/debounce, IDLE/RUN/PAUSE/LAP FSM,
// tick prescaler. Define SW_AUTOSTOP_EN to stop in PAUSE at 59:59 instead of wrapping to 00:00.
module stopwatch_ctrl #(
  parameter int DB_CYCLES = 16,
  parameter int DB_W      = 5,
  parameter int TICK_DIV  = 1,
  parameter int TD_W      = 4
) (
  input  logic             clock,
  input  logic             reset,
  stopwatch_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10,
    LAP   = 2'b11
  } state_t;

`ifdef SW_AUTOSTOP_EN
  localparam bit AUTOSTOP = 1'b1;
`else
  localparam bit AUTOSTOP = 1'b0;
`endif

  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);
  localparam logic [TD_W-1:0] TD_LAST = TD_W'(TICK_DIV - 1);

  // Button bit order everywhere: [0] start/stop, [1] lap, [2] clear.
  logic [2:0]            sync1_q, sync2_q;
  logic [2:0]            db_level_q, db_level_d;
  logic [2:0][DB_W-1:0]  db_cnt_q, db_cnt_d;
  logic [2:0]            ev_raw;
  logic                  ev_ss, ev_lap, ev_clr;

  state_t                state_q, state_d;
  logic [TD_W-1:0]       presc_q, presc_d;
  logic                  inc_q, inc_d;
  logic                  clr_q, clr_d;
  logic                  lap_hold_q, lap_hold_d;
  logic                  active, qual;

  // NOTE: every always_comb output gets a default before any branch, so no path can infer a latch.
  always_comb begin
    db_level_d = db_level_q;
    db_cnt_d   = '0;
    ev_raw     = '0;
    for (int i = 0; i < 3; i++) begin
      if (sync2_q[i] != db_level_q[i]) begin
        if (db_cnt_q[i] == DB_LAST) begin
          db_level_d[i] = sync2_q[i];
          ev_raw[i]     = sync2_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  assign ev_clr = ev_raw[2];
  assign ev_ss  = ev_raw[0] & ~ev_raw[2];
  assign ev_lap = ev_raw[1] & ~ev_raw[0] & ~ev_raw[2];

  assign active = state_q[0];
  assign qual   = active && bus.tick && (presc_q == TD_LAST);

  always_comb begin
    state_d = state_q;
    clr_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (ev_clr)     clr_d   = 1'b1;
        else if (ev_ss) state_d = RUN;
      end
      RUN: begin
        if (ev_ss)       state_d = PAUSE;
        else if (ev_lap) state_d = LAP;
      end
      LAP: begin
        if (ev_ss)       state_d = PAUSE;
        else if (ev_lap) state_d = RUN;
      end
      PAUSE: begin
        if (ev_clr) begin
          state_d = IDLE;
          clr_d   = 1'b1;
        end else if (ev_ss) begin
          state_d = RUN;
        end
      end
      default: state_d = IDLE;
    endcase

    if (AUTOSTOP && qual && bus.chain_at_max) state_d = PAUSE;

    // A qualified tick only counts if we are still counting after this edge.
    inc_d      = qual && state_d[0];
    lap_hold_d = (state_d == LAP);

    presc_d = presc_q;
    if (clr_d || state_q == IDLE) presc_d = '0;
    else if (active && bus.tick)  presc_d = qual ? '0 : presc_q + 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      // Debounced levels start "pressed": a button held through reset must be released before it
      // can produce an event.
      db_level_q <= '1;
      db_cnt_q   <= '0;
      state_q    <= IDLE;
      presc_q    <= '0;
      inc_q      <= 1'b0;
      clr_q      <= 1'b0;
      lap_hold_q <= 1'b0;
    end else begin
      sync1_q    <= {bus.btn_clr, bus.btn_lap, bus.btn_ss};
      sync2_q    <= sync1_q;
      db_level_q <= db_level_d;
      db_cnt_q   <= db_cnt_d;
      state_q    <= state_d;
      presc_q    <= presc_d;
      inc_q      <= inc_d;
      clr_q      <= clr_d;
      lap_hold_q <= lap_hold_d;
    end
  end

  assign bus.inc      = inc_q;
  assign bus.clr      = clr_q;
  assign bus.lap_hold = lap_hold_q;
  assign bus.running  = state_q[0];
  assign bus.state    = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl: two instances (TICK_DIV=1 and TICK_DIV=3, DB_CYCLES=4)
// share one stimulus stream; inputs driven and outputs sampled on the falling edge.
module tb_stopwatch_ctrl;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  stopwatch_ctrl_if bus_a ();
  stopwatch_ctrl_if bus_b ();

  assign bus_b.tick         = bus_a.tick;
  assign bus_b.btn_ss       = bus_a.btn_ss;
  assign bus_b.btn_lap      = bus_a.btn_lap;
  assign bus_b.btn_clr      = bus_a.btn_clr;
  assign bus_b.chain_at_max = bus_a.chain_at_max;

  stopwatch_ctrl #(.DB_CYCLES(4), .DB_W(3), .TICK_DIV(1), .TD_W(2)) u_dut_a (
    .clock (clock),
    .reset (reset),
    .bus   (bus_a.slave)
  );

  stopwatch_ctrl #(.DB_CYCLES(4), .DB_W(3), .TICK_DIV(3), .TD_W(2)) u_dut_b (
    .clock (clock),
    .reset (reset),
    .bus   (bus_b.slave)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic step(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Press the buttons in mask ({clr,lap,ss}) for 8 cycles, release for 8; watch clr pulses.
  task automatic press(input logic [2:0] mask, output int clr_cnt, output bit saw_run);
    clr_cnt = 0;
    saw_run = 1'b0;
    {bus_a.btn_clr, bus_a.btn_lap, bus_a.btn_ss} = mask;
    for (int i = 0; i < 16; i++) begin
      if (i == 8) {bus_a.btn_clr, bus_a.btn_lap, bus_a.btn_ss} = 3'b000;
      @(negedge clock);
      if (bus_a.clr) clr_cnt++;
      if (bus_a.state == 2'b01) saw_run = 1'b1;
      n_vec++;
      if (bus_a.clr && bus_a.inc) begin
        n_err++;
        $display("FAIL clr_with_inc: got inc=%b clr=%b required not both 1", bus_a.inc, bus_a.clr);
      end
    end
  endtask

  task automatic do_ticks(input int n, output int inc_a, output int inc_b);
    inc_a = 0;
    inc_b = 0;
    for (int i = 0; i < n; i++) begin
      bus_a.tick = 1'b1;
      @(negedge clock);
      bus_a.tick = 1'b0;
      if (bus_a.inc) inc_a++;
      if (bus_b.inc) inc_b++;
      @(negedge clock);
      if (bus_a.inc) inc_a++;
      if (bus_b.inc) inc_b++;
    end
  endtask

  task automatic test_reset();
    int pulses;
    bus_a.btn_ss = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bus_a.tick = ~bus_a.tick;
      step(1);
    end
    n_vec++;
    if ({bus_a.inc, bus_a.clr, bus_a.lap_hold, bus_a.running, bus_a.state} !== 6'b0) begin
      n_err++;
      $display("FAIL reset_outputs_a: got %b required 000000",
               {bus_a.inc, bus_a.clr, bus_a.lap_hold, bus_a.running, bus_a.state});
    end
    n_vec++;
    if ({bus_b.inc, bus_b.clr, bus_b.lap_hold, bus_b.running, bus_b.state} !== 6'b0) begin
      n_err++;
      $display("FAIL reset_outputs_b: got %b required 000000",
               {bus_b.inc, bus_b.clr, bus_b.lap_hold, bus_b.running, bus_b.state});
    end
    bus_a.tick = 1'b0;
    reset = 1'b1;
    step(12);
    n_vec++;
    if (bus_a.state !== 2'b00) begin
      n_err++;
      $display("FAIL held_btn_no_event: got state %b required 00", bus_a.state);
    end
    bus_a.btn_ss = 1'b0;
    step(8);
    bus_a.btn_ss = 1'b1;
    step(8);
    bus_a.btn_ss = 1'b0;
    n_vec++;
    if (bus_a.state !== 2'b01) begin
      n_err++;
      $display("FAIL repress_after_reset: got state %b required 01", bus_a.state);
    end
    step(8);
    #2 reset = 1'b0;
    #1;
    n_vec++;
    if ({bus_a.running, bus_a.state} !== 3'b000) begin
      n_err++;
      $display("FAIL async_reset_midrun: got %b required 000", {bus_a.running, bus_a.state});
    end
    @(negedge clock);
    reset = 1'b1;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      if (bus_a.inc || bus_a.clr || bus_a.state != 2'b00) pulses++;
    end
    n_vec++;
    if (pulses !== 0) begin
      n_err++;
      $display("FAIL reset_release_quiet: got %0d active cycles required 0", pulses);
    end
  endtask

  task automatic test_bounce();
    int cyc;
    for (int i = 0; i < 5; i++) begin
      bus_a.btn_ss = 1'b1;
      step(2);
      bus_a.btn_ss = 1'b0;
      step(2);
    end
    n_vec++;
    if (bus_a.state !== 2'b00) begin
      n_err++;
      $display("FAIL bounce_rejected: got state %b required 00", bus_a.state);
    end
    bus_a.btn_ss = 1'b1;
    cyc = 0;
    while (bus_a.state != 2'b01 && cyc < 20) begin
      step(1);
      cyc++;
    end
    n_vec++;
    if (cyc < 4 || cyc > 10) begin
      n_err++;
      $display("FAIL bounce_latency: got %0d cycles required 4..10", cyc);
    end
    step(8);
    bus_a.btn_ss = 1'b0;
    step(8);
    n_vec++;
    if (bus_a.state !== 2'b01) begin
      n_err++;
      $display("FAIL bounce_single_event: got state %b required 01", bus_a.state);
    end
    bus_a.tick = 1'b1;
    @(negedge clock);
    bus_a.tick = 1'b0;
    n_vec++;
    if (bus_a.inc !== 1'b1) begin
      n_err++;
      $display("FAIL inc_after_tick: got %b required 1", bus_a.inc);
    end
    @(negedge clock);
    n_vec++;
    if (bus_a.inc !== 1'b0) begin
      n_err++;
      $display("FAIL inc_one_cycle: got %b required 0", bus_a.inc);
    end
  endtask

  task automatic test_lap();
    int ia, ib, cc;
    bit sr;
    do_ticks(10, ia, ib);
    n_vec++;
    if (ia !== 10) begin n_err++; $display("FAIL run_inc_count: got %0d required 10", ia); end
    n_vec++;
    if (ib !== 3) begin n_err++; $display("FAIL run_inc_div3: got %0d required 3", ib); end
    press(3'b010, cc, sr);
    n_vec++;
    if ({bus_a.lap_hold, bus_a.state} !== 3'b111) begin
      n_err++;
      $display("FAIL lap_enter: got %b required 111", {bus_a.lap_hold, bus_a.state});
    end
    do_ticks(3, ia, ib);
    n_vec++;
    if (ia !== 3) begin n_err++; $display("FAIL lap_inc_count: got %0d required 3", ia); end
    n_vec++;
    if (ib !== 1) begin n_err++; $display("FAIL lap_inc_div3: got %0d required 1", ib); end
    press(3'b010, cc, sr);
    n_vec++;
    if ({bus_a.lap_hold, bus_a.state} !== 3'b001) begin
      n_err++;
      $display("FAIL lap_exit: got %b required 001", {bus_a.lap_hold, bus_a.state});
    end
  endtask

  task automatic test_pause_clear();
    int ia, ib, cc;
    bit sr;
    press(3'b001, cc, sr);
    n_vec++;
    if ({bus_a.running, bus_a.state} !== 3'b010) begin
      n_err++;
      $display("FAIL pause_enter: got %b required 010", {bus_a.running, bus_a.state});
    end
    do_ticks(4, ia, ib);
    n_vec++;
    if (ia + ib !== 0) begin n_err++; $display("FAIL pause_no_inc: got %0d required 0", ia + ib); end
    press(3'b001, cc, sr);
    do_ticks(1, ia, ib);
    n_vec++;
    if (ib !== 1) begin n_err++; $display("FAIL presc_held: got %0d required 1", ib); end
    do_ticks(2, ia, ib);
    n_vec++;
    if (ib !== 0) begin n_err++; $display("FAIL presc_resume: got %0d required 0", ib); end
    press(3'b001, cc, sr);
    press(3'b100, cc, sr);
    n_vec++;
    if (cc !== 1) begin n_err++; $display("FAIL pause_clr_pulse: got %0d required 1", cc); end
    n_vec++;
    if (bus_a.state !== 2'b00) begin
      n_err++;
      $display("FAIL pause_clr_state: got %b required 00", bus_a.state);
    end
    press(3'b001, cc, sr);
    do_ticks(2, ia, ib);
    n_vec++;
    if (ib !== 0) begin n_err++; $display("FAIL presc_cleared: got %0d required 0", ib); end
    do_ticks(1, ia, ib);
    n_vec++;
    if (ib !== 1) begin n_err++; $display("FAIL presc_third_tick: got %0d required 1", ib); end
    press(3'b100, cc, sr);
    n_vec++;
    if (cc !== 0) begin n_err++; $display("FAIL run_clr_ignored: got %0d required 0", cc); end
    n_vec++;
    if (bus_a.state !== 2'b01) begin
      n_err++;
      $display("FAIL run_clr_state: got %b required 01", bus_a.state);
    end
  endtask

  task automatic test_same_cycle();
    int cc;
    bit sr;
    press(3'b001, cc, sr);
    press(3'b101, cc, sr);
    n_vec++;
    if (cc !== 1) begin n_err++; $display("FAIL same_cycle_clr: got %0d required 1", cc); end
    n_vec++;
    if (sr !== 1'b0) begin n_err++; $display("FAIL same_cycle_no_run: got %b required 0", sr); end
    n_vec++;
    if (bus_a.state !== 2'b00) begin
      n_err++;
      $display("FAIL same_cycle_state: got %b required 00", bus_a.state);
    end
  endtask

  task automatic test_rollover();
    int cc;
    bit sr;
    logic       exp_inc;
    logic [1:0] exp_state;
`ifdef SW_AUTOSTOP_EN
    exp_inc   = 1'b0;
    exp_state = 2'b10;
`else
    exp_inc   = 1'b1;
    exp_state = 2'b01;
`endif
    press(3'b001, cc, sr);
    bus_a.chain_at_max = 1'b1;
    bus_a.tick = 1'b1;
    @(negedge clock);
    bus_a.tick = 1'b0;
    n_vec++;
    if (bus_a.inc !== exp_inc) begin
      n_err++;
      $display("FAIL rollover_inc: got %b required %b", bus_a.inc, exp_inc);
    end
    n_vec++;
    if (bus_a.state !== exp_state) begin
      n_err++;
      $display("FAIL rollover_state: got %b required %b", bus_a.state, exp_state);
    end
    @(negedge clock);
    bus_a.chain_at_max = 1'b0;
  endtask

  initial begin
    bus_a.tick         = 1'b0;
    bus_a.btn_ss       = 1'b0;
    bus_a.btn_lap      = 1'b0;
    bus_a.btn_clr      = 1'b0;
    bus_a.chain_at_max = 1'b0;
    @(negedge clock);
    test_reset();
    test_bounce();
    test_lap();
    test_pause_clear();
    test_same_cycle();
    test_rollover();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
